// File: rtl/mux_pkg.sv
// Shared definitions for the registered round-robin / fixed-select word multiplexer.
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first requesting channel scanning upward from ptr+1, wrapping.
module rr_pick #(
    parameter int NCH  = 8,
    parameter int SELW = $clog2(NCH)
) (
    input  logic [NCH-1:0]  req,
    input  logic [SELW-1:0] ptr,
    output logic [SELW-1:0] grant,
    output logic            any
);

    int idx;

    // Scan from lowest priority (ptr itself) to highest (ptr+1) so the last hit wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        for (int k = NCH; k >= 1; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NCH) begin
                idx = idx - NCH;
            end
            if (req[SELW'(idx)]) begin
                grant = SELW'(idx);
                any   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_arb_rr.sv
// N-channel registered word multiplexer with fixed or round-robin selection and
// burst-level grant locking; one output register stage with valid/ready.
module mux_arb_rr
    import mux_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NCH   = 8,
    parameter int SELW  = $clog2(NCH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [NCH*WIDTH-1:0] in_data,
    input  logic [NCH-1:0]       in_valid,
    input  logic [NCH-1:0]       in_last,
    output logic [NCH-1:0]       in_ready,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_ch,
    output logic                 out_last,
    output logic                 out_valid,
    input  logic                 out_ready
);

    arb_state_t      state, next_state;
    logic [SELW-1:0] rr_ptr;
    logic [SELW-1:0] lock_ch;
    logic [SELW-1:0] rr_grant;
    logic            rr_any;
    logic [SELW-1:0] grant;
    logic            grant_any;
    logic            grant_last;
    logic            load;
    logic            xfer;

    rr_pick #(
        .NCH  (NCH),
        .SELW (SELW)
    ) u_rr_pick (
        .req   (in_valid),
        .ptr   (rr_ptr),
        .grant (rr_grant),
        .any   (rr_any)
    );

    assign load = !out_valid || out_ready;

    // NOTE: every signal written here gets a default first, so no latch is inferred.
    always_comb begin
        grant      = lock_ch;
        grant_any  = 1'b0;
        grant_last = 1'b0;
        xfer       = 1'b0;
        in_ready   = '0;
        next_state = state;

        if (state == LOCKED) begin
            grant     = lock_ch;
            grant_any = in_valid[lock_ch];
        end else begin
            case (mode)
                MODE_RR: begin
                    grant     = rr_grant;
                    grant_any = rr_any;
                end
                MODE_FIXED: begin
                    grant     = sel;
                    grant_any = (int'(sel) < NCH) && in_valid[sel];
                end
                default: ;
            endcase
        end

        xfer = load && grant_any;
        if (xfer) begin
            grant_last      = in_last[grant];
            in_ready[grant] = 1'b1;
            next_state      = grant_last ? IDLE : LOCKED;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            lock_ch <= '0;
            rr_ptr  <= SELW'(NCH - 1);
        end else begin
            state <= next_state;
            if (xfer) begin
                if (grant_last) begin
                    rr_ptr <= grant;
                end else begin
                    lock_ch <= grant;
                end
            end
        end
    end

    // The whole output register is reset, data included, because its reset value is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data  <= '0;
            out_ch    <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (xfer) begin
            out_data  <= in_data[grant*WIDTH +: WIDTH];
            out_ch    <= grant;
            out_last  <= grant_last;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux_arb_rr.sv
// Self-checking bench for mux_arb_rr: directed scenarios plus randomized traffic
// checked against a channel/burst-level reference model.
`timescale 1ns/1ps
module tb_mux_arb_rr;

    localparam int W  = 16;
    localparam int N  = 8;
    localparam int SW = 3;
    localparam int W3 = 8;
    localparam int N3 = 3;
    localparam int S3 = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // 8-channel, 16-bit instance
    logic          a_mode;
    logic [SW-1:0] a_sel;
    logic [N*W-1:0] a_data;
    logic [N-1:0]  a_valid, a_last, a_ready;
    logic [W-1:0]  a_odata;
    logic [SW-1:0] a_och;
    logic          a_olast, a_ovalid, a_oready;

    // 3-channel, 8-bit instance
    logic          b_mode;
    logic [S3-1:0] b_sel;
    logic [N3*W3-1:0] b_data;
    logic [N3-1:0] b_valid, b_last, b_ready;
    logic [W3-1:0] b_odata;
    logic [S3-1:0] b_och;
    logic          b_olast, b_ovalid, b_oready;

    mux_arb_rr #(.WIDTH(W), .NCH(N)) dut_a (
        .clk(clk), .rst(rst), .mode(a_mode), .sel(a_sel),
        .in_data(a_data), .in_valid(a_valid), .in_last(a_last), .in_ready(a_ready),
        .out_data(a_odata), .out_ch(a_och), .out_last(a_olast), .out_valid(a_ovalid),
        .out_ready(a_oready)
    );

    mux_arb_rr #(.WIDTH(W3), .NCH(N3)) dut_b (
        .clk(clk), .rst(rst), .mode(b_mode), .sel(b_sel),
        .in_data(b_data), .in_valid(b_valid), .in_last(b_last), .in_ready(b_ready),
        .out_data(b_odata), .out_ch(b_och), .out_last(b_olast), .out_valid(b_ovalid),
        .out_ready(b_oready)
    );

    // Reference model: lock channel (-1 when free), last channel to finish a burst, output slot.
    int         m_lock;
    int         m_ptr;
    logic       m_ov;
    logic       m_ol;
    logic [W-1:0] m_od;
    int         m_och;

    logic [20:0] a_out;
    assign a_out = {a_ovalid, a_olast, a_och, a_odata};

    function automatic logic [20:0] m_out();
        return {m_ov, m_ol, SW'(m_och), m_od};
    endfunction

    task automatic model_reset();
        m_lock = -1;
        m_ptr  = N - 1;
        m_ov   = 1'b0;
        m_ol   = 1'b0;
        m_od   = '0;
        m_och  = 0;
    endtask

    // Channel the model expects to be accepted this cycle, or -1.
    function automatic int a_grant();
        int c;
        if (m_ov && !a_oready) return -1;
        if (m_lock >= 0) return a_valid[m_lock] ? m_lock : -1;
        if (a_mode == 1'b0) return a_valid[a_sel] ? int'(a_sel) : -1;
        for (int k = 1; k <= N; k++) begin
            c = (m_ptr + k) % N;
            if (a_valid[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] onehot(int g);
        logic [N-1:0] r;
        r = '0;
        if (g >= 0) r[g] = 1'b1;
        return r;
    endfunction

    task automatic a_tick();
        int g;
        g = a_grant();
        @(posedge clk);
        if (g >= 0) begin
            m_od  = a_data[g*W +: W];
            m_och = g;
            m_ol  = a_last[g];
            m_ov  = 1'b1;
            if (a_last[g]) begin
                m_lock = -1;
                m_ptr  = g;
            end else begin
                m_lock = g;
            end
        end else if (a_oready) begin
            m_ov = 1'b0;
        end
        #1;
    endtask

    task automatic set_pattern();
        for (int c = 0; c < N; c++) a_data[c*W +: W] = 16'hA000 + 16'(c);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_mode = 1'b0; a_sel = '0; a_data = '0; a_valid = '0; a_last = '0; a_oready = 1'b0;
        b_mode = 1'b0; b_sel = '0; b_data = '0; b_valid = '0; b_last = '0; b_oready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (a_out !== 21'h0 || a_ready !== 8'h00) begin
            errors++;
            $display("FAIL reset_a out=%h ready=%h expected out=0 ready=0", a_out, a_ready);
        end
        checks++;
        if ({b_ovalid, b_olast, b_och, b_odata} !== 12'h0 || b_ready !== 3'b000) begin
            errors++;
            $display("FAIL reset_b out=%h ready=%b expected 0", {b_ovalid, b_olast, b_och, b_odata}, b_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_rr_sweep();
        a_mode = 1'b1; a_valid = 8'hFF; a_last = 8'hFF; a_oready = 1'b1;
        set_pattern();
        for (int i = 0; i < 9; i++) begin
            #1;
            checks++;
            if (a_ready !== onehot(i % N)) begin
                errors++;
                $display("FAIL rr_sweep_ready beat %0d got %b expected %b", i, a_ready, onehot(i % N));
            end
            a_tick();
            checks++;
            if (a_ovalid !== 1'b1 || a_och !== SW'(i % N) || a_odata !== 16'hA000 + 16'(i % N)) begin
                errors++;
                $display("FAIL rr_sweep_out beat %0d got v=%b ch=%0d d=%h expected ch=%0d", i, a_ovalid, a_och, a_odata, i % N);
            end
        end
    endtask

    task automatic test_fixed_select();
        a_mode = 1'b0; a_sel = 3'd5; a_valid = 8'h24; a_last = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) a_sel = 3'd2;
            #1;
            checks++;
            if (a_ready !== (i == 3 ? 8'h04 : 8'h20)) begin
                errors++;
                $display("FAIL fixed_ready beat %0d got %b", i, a_ready);
            end
            a_tick();
            checks++;
            if (a_out !== m_out() || a_och !== (i == 3 ? 3'd2 : 3'd5)) begin
                errors++;
                $display("FAIL fixed_out beat %0d got %h expected %h", i, a_out, m_out());
            end
        end
    endtask

    task automatic test_burst_lock();
        int exp_ch [5] = '{3, 3, 3, 3, 1};
        a_mode = 1'b1; a_valid = 8'h0A; a_last = 8'h02;
        for (int b = 0; b < 5; b++) begin
            a_data[3*W +: W] = 16'h3000 + 16'(b);
            if (b == 3) a_last[3] = 1'b1;
            if (b == 4) a_valid[3] = 1'b0;
            #1;
            checks++;
            if (a_ready !== onehot(exp_ch[b]) || a_ready !== onehot(a_grant())) begin
                errors++;
                $display("FAIL burst_ready beat %0d got %b expected %b", b, a_ready, onehot(exp_ch[b]));
            end
            a_tick();
            checks++;
            if (a_out !== m_out() || a_och !== SW'(exp_ch[b])) begin
                errors++;
                $display("FAIL burst_out beat %0d got %h expected %h", b, a_out, m_out());
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W-1:0] held;
        a_mode = 1'b1; a_valid = 8'hFF; a_last = 8'hFF; a_oready = 1'b1;
        set_pattern();
        #1;
        a_tick();
        held = a_odata;
        a_oready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (a_ready !== 8'h00) begin
                errors++;
                $display("FAIL bp_ready cycle %0d got %b expected 00000000", i, a_ready);
            end
            a_tick();
            checks++;
            if (a_odata !== held || a_ovalid !== 1'b1 || a_out !== m_out()) begin
                errors++;
                $display("FAIL bp_hold cycle %0d got d=%h v=%b expected d=%h v=1", i, a_odata, a_ovalid, held);
            end
        end
        a_oready = 1'b1;
        #1;
        checks++;
        if (a_ready === 8'h00 || a_ready !== onehot(a_grant())) begin
            errors++;
            $display("FAIL bp_release_ready got %b expected %b", a_ready, onehot(a_grant()));
        end
        a_tick();
        checks++;
        if (a_out !== m_out() || a_odata === held) begin
            errors++;
            $display("FAIL bp_release_out got %h expected %h", a_out, m_out());
        end
    endtask

    task automatic test_reset_mid_burst();
        a_mode = 1'b0; a_sel = 3'd6; a_valid = 8'h40; a_last = 8'h00; a_oready = 1'b1;
        a_data[6*W +: W] = 16'h6001;
        #1;
        a_tick();
        checks++;
        if (a_och !== 3'd6 || a_odata !== 16'h6001 || a_ovalid !== 1'b1) begin
            errors++;
            $display("FAIL rst_beat1 got ch=%0d d=%h v=%b expected ch=6 d=6001 v=1", a_och, a_odata, a_ovalid);
        end
        a_data[6*W +: W] = 16'h6002;
        a_sel = 3'd0;
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (a_out !== 21'h0) begin
            errors++;
            $display("FAIL rst_async got %h expected 0", a_out);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        a_mode = 1'b1; a_valid = 8'h41; a_last = 8'hFF;
        #1;
        checks++;
        if (a_ready !== 8'h01) begin
            errors++;
            $display("FAIL rst_regrant_ready got %b expected 00000001", a_ready);
        end
        a_tick();
        checks++;
        if (a_out !== m_out() || a_och !== 3'd0) begin
            errors++;
            $display("FAIL rst_regrant_out got %h expected %h", a_out, m_out());
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            a_mode   = 1'($urandom);
            a_sel    = SW'($urandom);
            a_valid  = 8'($urandom);
            a_last   = 8'($urandom) & 8'($urandom);
            a_oready = ($urandom % 4) != 0;
            for (int c = 0; c < N; c++) a_data[c*W +: W] = 16'($urandom);
            #1;
            checks++;
            if (a_ready !== onehot(a_grant())) begin
                errors++;
                $display("FAIL rand_ready cycle %0d got %b expected %b", i, a_ready, onehot(a_grant()));
            end
            a_tick();
            checks++;
            if (a_out !== m_out()) begin
                errors++;
                $display("FAIL rand_out cycle %0d got %h expected %h", i, a_out, m_out());
            end
        end
        a_valid = '0;
    endtask

    task automatic test_small_instance();
        b_mode = 1'b1; b_valid = 3'b111; b_last = 3'b111; b_oready = 1'b1;
        b_data = {8'h12, 8'h11, 8'h10};
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (b_ready !== 3'(1 << (i % N3))) begin
                errors++;
                $display("FAIL small_rr_ready beat %0d got %b", i, b_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (b_ovalid !== 1'b1 || b_och !== S3'(i % N3) || b_odata !== 8'h10 + 8'(i % N3)) begin
                errors++;
                $display("FAIL small_rr_out beat %0d got v=%b ch=%0d d=%h expected ch=%0d", i, b_ovalid, b_och, b_odata, i % N3);
            end
        end
        b_mode = 1'b0; b_sel = 2'd3;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if (b_ready !== 3'b000) begin
                errors++;
                $display("FAIL small_sel3_ready cycle %0d got %b expected 000", i, b_ready);
            end
            @(posedge clk);
            #1;
            checks++;
            if (b_ovalid !== 1'b0) begin
                errors++;
                $display("FAIL small_sel3_drain cycle %0d got v=%b expected 0", i, b_ovalid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_rr_sweep();
        test_fixed_select();
        test_burst_lock();
        test_backpressure();
        test_reset_mid_burst();
        test_random();
        test_small_instance();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
